// File: rtl/pipe_fwd_unit.sv
// Operand forwarding / hazard unit: tracks destination writes through STAGES post-issue
// stages and picks the youngest producer per source. PIPE_FWD_UNIT_FWD_EN enables forwarding; otherwise full interlock.
module pipe_fwd_unit #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STAGES     = 3,
   parameter int NSRC       = 2,
   parameter int LOAD_STAGE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pipe_en,
   input  logic                     issue_valid,
   input  logic                     issue_wen,
   input  logic                     issue_load,
   input  logic [ADDR_W-1:0]        issue_waddr,
   input  logic [STAGES-1:0]        flush_mask,
   input  logic [NSRC*ADDR_W-1:0]   src_addr,
   input  logic [NSRC-1:0]          src_used,
   input  logic [NSRC*DATA_W-1:0]   rf_data,
   input  logic [STAGES*DATA_W-1:0] stage_data,
   output logic [NSRC*4-1:0]        fwd_sel,
   output logic [NSRC*DATA_W-1:0]   fwd_data,
   output logic                     stall
);

   typedef struct packed {
      logic              valid;
      logic              wen;
      logic              load;
      logic [ADDR_W-1:0] waddr;
   } entry_t;

   entry_t            ent     [STAGES];
   entry_t            shifted [STAGES];
   logic [STAGES-1:0] match   [NSRC];

   // Stage 0 takes the ID instruction only when it is not held back by a hazard.
   always_comb begin
      shifted[0] = '0;
      if (issue_valid && !stall) begin
         shifted[0].valid = 1'b1;
         shifted[0].wen   = issue_wen;
         shifted[0].load  = issue_load;
         shifted[0].waddr = issue_waddr;
      end
      for (int k = 1; k < STAGES; k++) shifted[k] = ent[k-1];
   end

   // NOTE: the tracking entries are a handful of flops whose valid bits must be
   // cleared by reset, so the whole array is reset (unlike a datapath RAM).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) ent[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (flush_mask[k])  ent[k] <= '0;
            else if (pipe_en)   ent[k] <= shifted[k];
         end
      end
   end

   always_comb begin
      for (int s = 0; s < NSRC; s++) begin
         match[s] = '0;
         for (int k = 0; k < STAGES; k++) begin
            match[s][k] = src_used[s] && ent[k].valid && ent[k].wen &&
                          (ent[k].waddr == src_addr[s*ADDR_W +: ADDR_W]) &&
                          (src_addr[s*ADDR_W +: ADDR_W] != '0);
         end
      end
   end

`ifdef PIPE_FWD_UNIT_FWD_EN
   logic [NSRC-1:0] found;

   // Ascending scan: the first hit is the youngest writer, which owns the value.
   always_comb begin
      stall    = 1'b0;
      fwd_sel  = '0;
      fwd_data = rf_data;
      found    = '0;
      for (int s = 0; s < NSRC; s++) begin
         for (int k = 0; k < STAGES; k++) begin
            if (match[s][k] && !found[s]) begin
               found[s]                      = 1'b1;
               fwd_sel[s*4 +: 4]             = 4'(k + 1);
               fwd_data[s*DATA_W +: DATA_W]  = stage_data[k*DATA_W +: DATA_W];
               if (ent[k].load && (k < LOAD_STAGE)) stall = 1'b1;
            end
         end
      end
   end
`else
   logic [STAGES-1:0] unused_load;
   logic              unused_cfg;

   assign fwd_sel  = '0;
   assign fwd_data = rf_data;

   always_comb begin
      stall = 1'b0;
      for (int s = 0; s < NSRC; s++) stall = stall | (|match[s]);
   end

   // Load/stage data only matter when forwarding; keep them visibly consumed.
   always_comb begin
      for (int k = 0; k < STAGES; k++) unused_load[k] = ent[k].load;
   end
   assign unused_cfg = ^{stage_data, unused_load, (LOAD_STAGE >= 1) && (LOAD_STAGE < STAGES)};
`endif

endmodule

// File: tb/tb_pipe_fwd_unit.sv
// Directed bench for pipe_fwd_unit (STAGES=3, NSRC=2, LOAD_STAGE=1); expectations follow
// the build: forwarding when PIPE_FWD_UNIT_FWD_EN is defined, full interlock otherwise.
module tb_pipe_fwd_unit;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int ST = 3;
   localparam int NS = 2;
   localparam int NV = 14;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            pipe_en, issue_valid, issue_wen, issue_load;
   logic [AW-1:0]   issue_waddr;
   logic [ST-1:0]   flush_mask;
   logic [NS*AW-1:0] src_addr;
   logic [NS-1:0]   src_used;
   logic [NS*DW-1:0] rf_data;
   logic [ST*DW-1:0] stage_data;
   logic [NS*4-1:0] fwd_sel;
   logic [NS*DW-1:0] fwd_data;
   logic            stall;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic          pe, iv, iw, il;
      logic [AW-1:0] ia;
      logic [ST-1:0] fl;
      logic [AW-1:0] s0, s1;
      logic [1:0]    used;
      logic          st;
      logic [3:0]    sel0, sel1;
   } vec_t;

   vec_t tbl [NV];

   pipe_fwd_unit #(.DATA_W(DW), .ADDR_W(AW), .STAGES(ST), .NSRC(NS), .LOAD_STAGE(1)) dut (
      .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .issue_valid(issue_valid),
      .issue_wen(issue_wen), .issue_load(issue_load), .issue_waddr(issue_waddr),
      .flush_mask(flush_mask), .src_addr(src_addr), .src_used(src_used),
      .rf_data(rf_data), .stage_data(stage_data), .fwd_sel(fwd_sel),
      .fwd_data(fwd_data), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic pe, iv, iw, il, input int ia, input logic [ST-1:0] fl,
                               input int s0, s1, input logic [1:0] used,
                               input logic st, input int sel0, sel1);
      vec_t v;
      v.pe = pe; v.iv = iv; v.iw = iw; v.il = il; v.ia = AW'(ia); v.fl = fl;
      v.s0 = AW'(s0); v.s1 = AW'(s1); v.used = used;
      v.st = st; v.sel0 = 4'(sel0); v.sel1 = 4'(sel1);
      return v;
   endfunction

   function automatic logic [31:0] exp_data(input int s, input logic [3:0] sel);
      if (sel == 4'd0) return rf_data[s*DW +: DW];
      return stage_data[(int'(sel)-1)*DW +: DW];
   endfunction

   task automatic check_outputs(input string tag, input logic st, input logic [3:0] sel0, input logic [3:0] sel1);
      check({tag, ".stall"}, 32'(stall), 32'(st));
      check({tag, ".sel0"}, 32'(fwd_sel[3:0]), 32'(sel0));
      check({tag, ".sel1"}, 32'(fwd_sel[7:4]), 32'(sel1));
      check({tag, ".data0"}, fwd_data[31:0], exp_data(0, sel0));
      check({tag, ".data1"}, fwd_data[63:32], exp_data(1, sel1));
   endtask

   task automatic drive_idle();
      pipe_en = 1'b1; issue_valid = 1'b0; issue_wen = 1'b0; issue_load = 1'b0;
      issue_waddr = '0; flush_mask = '0; src_addr = '0; src_used = '0;
   endtask

   initial begin
      rf_data    = {32'h1111_0001, 32'h1111_0000};
      stage_data = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      drive_idle();
      src_addr = {AW'(4), AW'(3)}; src_used = 2'b11;
      rst_n = 1'b0;

`ifdef PIPE_FWD_UNIT_FWD_EN
      tbl[0]  = mk(1,1,1,0, 3,3'b000,  3, 4,2'b11, 0,0,0);
      tbl[1]  = mk(1,0,0,0, 0,3'b000,  3, 4,2'b01, 0,1,0);
      tbl[2]  = mk(1,1,1,0, 3,3'b000,  3, 4,2'b01, 0,2,0);
      tbl[3]  = mk(1,1,1,0, 3,3'b000,  3, 4,2'b01, 0,1,0);
      tbl[4]  = mk(1,1,1,1, 4,3'b000,  3, 3,2'b11, 0,1,1);
      tbl[5]  = mk(1,1,1,0,10,3'b000,  3, 4,2'b11, 1,2,1);
      tbl[6]  = mk(1,1,1,0,10,3'b000,  3, 4,2'b11, 0,3,2);
      tbl[7]  = mk(1,1,1,0, 0,3'b000,  0, 4,2'b11, 0,0,3);
      tbl[8]  = mk(1,1,1,0, 5,3'b001,  0,10,2'b01, 0,0,0);
      tbl[9]  = mk(1,1,0,0,11,3'b000,  5,10,2'b11, 0,0,3);
      tbl[10] = mk(0,1,1,1,12,3'b000, 11, 0,2'b01, 0,0,0);
      tbl[11] = mk(1,1,1,1,12,3'b000, 12, 0,2'b11, 0,0,0);
      tbl[12] = mk(0,0,0,0, 0,3'b001, 12, 0,2'b01, 1,1,0);
      tbl[13] = mk(1,0,0,0, 0,3'b000, 12,11,2'b11, 0,0,0);
`else
      tbl[0]  = mk(1,1,1,0, 6,3'b000,  3, 4,2'b11, 0,0,0);
      tbl[1]  = mk(1,1,1,0, 7,3'b000,  6, 0,2'b01, 1,0,0);
      tbl[2]  = mk(1,1,1,0, 7,3'b000,  6, 0,2'b01, 1,0,0);
      tbl[3]  = mk(1,1,1,0, 7,3'b000,  6, 0,2'b01, 1,0,0);
      tbl[4]  = mk(1,1,1,0, 7,3'b000,  6, 0,2'b01, 0,0,0);
      tbl[5]  = mk(1,1,1,0, 0,3'b000,  0, 7,2'b01, 0,0,0);
      tbl[6]  = mk(1,0,0,0, 0,3'b000,  0, 5,2'b11, 0,0,0);
      tbl[7]  = mk(0,1,1,0, 5,3'b000,  0, 7,2'b10, 1,0,0);
      tbl[8]  = mk(0,1,1,0, 5,3'b100,  0, 7,2'b10, 1,0,0);
      tbl[9]  = mk(1,1,1,0, 5,3'b001,  0, 7,2'b10, 0,0,0);
      tbl[10] = mk(1,1,0,0, 8,3'b000,  5, 0,2'b01, 0,0,0);
      tbl[11] = mk(0,1,1,0, 9,3'b000,  8, 0,2'b01, 0,0,0);
      tbl[12] = mk(1,1,1,1, 4,3'b000,  8, 9,2'b11, 0,0,0);
      tbl[13] = mk(1,0,0,0, 0,3'b000,  0, 4,2'b10, 1,0,0);
`endif

      // Reset state, checked while reset is still held.
      repeat (2) @(posedge clk);
      #1 check_outputs("reset", 1'b0, 4'd0, 4'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         pipe_en     = tbl[i].pe;
         issue_valid = tbl[i].iv;
         issue_wen   = tbl[i].iw;
         issue_load  = tbl[i].il;
         issue_waddr = tbl[i].ia;
         flush_mask  = tbl[i].fl;
         src_addr    = {tbl[i].s1, tbl[i].s0};
         src_used    = tbl[i].used;
         #3 check_outputs($sformatf("vec%0d", i), tbl[i].st, tbl[i].sel0, tbl[i].sel1);
         @(posedge clk); #1;
      end

      // Asynchronous reset mid-cycle with a writer to r3 in stage 0.
      drive_idle();
      issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = AW'(3);
      @(posedge clk); #1;
      drive_idle();
      src_addr = {AW'(0), AW'(3)}; src_used = 2'b01;
      #2;
`ifdef PIPE_FWD_UNIT_FWD_EN
      check_outputs("pre_rst", 1'b0, 4'd1, 4'd0);
`else
      check_outputs("pre_rst", 1'b1, 4'd0, 4'd0);
`endif
      #1 rst_n = 1'b0;
      #1 check_outputs("async_rst", 1'b0, 4'd0, 4'd0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 check_outputs("post_rst", 1'b0, 4'd0, 4'd0);
      @(posedge clk); #1;
      check_outputs("post_rst_edge", 1'b0, 4'd0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_fwd_unit.md
PIPE_FWD_UNIT -- requirements
Module: pipe_fwd_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 The block SHALL have parameter STAGES, default 3 (legal 2..8), meaning tracked post-issue stages; index 0 is youngest (EXE).
REQ-004 The block SHALL have parameter NSRC, default 2 (legal 1..4), meaning source operand ports.
REQ-005 The block SHALL have parameter LOAD_STAGE, default 1 (legal 1..STAGES-1), meaning the first stage index holding load data.
REQ-006 The block SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 The block SHALL have port pipe_en, input, 1, which advances the tracked pipeline.
REQ-009 The block SHALL have ports issue_valid/issue_wen/issue_load, each input 1, describing the ID-stage instruction.
REQ-010 The block SHALL have port issue_waddr, input, ADDR_W, the ID-stage destination.
REQ-011 The block SHALL have port flush_mask, input, STAGES, which squashes the selected stages.
REQ-012 The block SHALL have ports src_addr (input NSRC*ADDR_W), src_used (input NSRC) and rf_data (input NSRC*DATA_W), the regfile read per source.
REQ-013 The block SHALL have port stage_data, input, STAGES*DATA_W, the result available in each stage.
REQ-014 The block SHALL have port fwd_sel, output, NSRC*4, per source: 0 = regfile, k = stage k-1.
REQ-015 The block SHALL have ports fwd_data (output NSRC*DATA_W, selected operand) and stall (output 1, hold ID/IF, bubble into stage 0).

Function
REQ-016 Each stage entry SHALL hold {valid, wen, waddr, load}.
REQ-017 On an edge with pipe_en=1, entry[k] SHALL load entry[k-1] and entry[0] SHALL load the issue fields if issue_valid & ~stall, else a bubble (valid=0); entry[STAGES-1] retires.
REQ-018 With pipe_en=0, all entries SHALL hold, except that flushes still apply.
REQ-019 flush_mask[k]=1 SHALL clear the value written into entry[k] at that edge, with priority over shift and issue.
REQ-020 A source SHALL match stage k when src_used, entry[k].valid, entry[k].wen, waddr==src_addr and src_addr!=0.
REQ-021 fwd_sel SHALL select the lowest matching k (youngest writer); with no match, fwd_sel=0 and fwd_data=rf_data.
REQ-022 stall SHALL be 1 when any used source's selected match has load=1 and k<LOAD_STAGE.
REQ-023 stall, fwd_sel and fwd_data SHALL be combinational from entries and inputs, with zero cycles of latency.
REQ-024 Address 0 SHALL never forward or stall.

Reset
REQ-025 With rst_n=0, all entries SHALL be invalid immediately (asynchronously), which yields stall=0, fwd_sel=0 and fwd_data=rf_data.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight entries; no partial state SHALL survive.

Configuration
REQ-027 With macro PIPE_FWD_UNIT_FWD_EN defined, forwarding SHALL operate per REQ-020..REQ-022.
REQ-028 Without PIPE_FWD_UNIT_FWD_EN, fwd_sel SHALL be tied 0, fwd_data SHALL equal rf_data, and stall SHALL be 1 whenever any used source matches any stage (full interlock).

Verification (STAGES=3, LOAD_STAGE=1, NSRC=2, FWD_EN on unless stated)
REQ-029 Drive rst_n=0 with entries populated -> stall=0 and fwd_sel=0 immediately, without waiting for a clock edge.
REQ-030 Issue a write to r3, then next cycle src0=r3 -> fwd_sel0=1 and fwd_data0=stage_data[0]; one cycle later -> fwd_sel0=2.
REQ-031 Writers to r3 present in both stage 0 and stage 1, src0=r3 -> fwd_sel0=1.
REQ-032 Issue a load to r4, then src1=r4 -> stall=1 for exactly one cycle (stage 0 becomes a bubble), then fwd_sel1=2 with the load data.
REQ-033 A write to r0 in flight with src0=r0 -> fwd_sel0=0 and stall=0; apply flush_mask=3'b001 on a writer to r5 -> next cycle, src r5 reads the regfile.
REQ-034 With FWD_EN off, issue a write to r6, then src0=r6 -> stall=1 for 3 cycles, then 0 with fwd_data0=rf_data.
